// File: rtl/si_div_seq.sv
// si_div_seq: sequential signed divider using a restoring algorithm.
// Produces one quotient bit per clock. Results appear N+1 cycles after
// START is captured. The quotient truncates toward zero and the remainder
// takes the sign of the dividend. Divide-by-zero and most-negative/-1
// overflow are flagged alongside the result.
module si_div_seq #(
   parameter int N = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic         o_busy,
   output logic         o_done,
   output logic [N-1:0] o_q,
   output logic [N-1:0] o_r,
   output logic         o_dbz,
   output logic         o_ovf
);

   localparam int           CW       = $clog2(N + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(N);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [N-1:0]  MIN_NEG  = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_cnt;
   logic [N-1:0]  r_rem;     // partial remainder magnitude
   logic [N-1:0]  r_dvd;     // dividend magnitude, shifted out as quotient bits shift in
   logic [N-1:0]  r_mb;      // divisor magnitude
   logic [N-1:0]  r_a;       // original signed dividend, returned as R on divide-by-zero
   logic          r_sga;
   logic          r_sgb;
   logic          r_dbz_p;
   logic          r_ovf_p;

   logic [N-1:0]  w_ma;
   logic [N-1:0]  w_mb;
   logic [N:0]    w_shift;
   logic [N:0]    w_trial;
   logic          w_qbit;
   logic [N-1:0]  w_q_fin;
   logic [N-1:0]  w_r_fin;

   // Magnitudes of the operands; the most-negative value maps to 2^(N-1).
   assign w_ma = i_a[N-1] ? -i_a : i_a;
   assign w_mb = i_b[N-1] ? -i_b : i_b;

   // Restoring step: shift in the next dividend bit, then trial-subtract the divisor.
   // A non-negative trial result produces a 1 quotient bit.
   assign w_shift = {r_rem, r_dvd[N-1]};
   assign w_trial = w_shift - {1'b0, r_mb};
   assign w_qbit  = ~w_trial[N];

   assign o_busy = (r_state != S_IDLE);

   // Apply signs to the magnitudes. Divide-by-zero and overflow override the result.
   always_comb begin
      w_q_fin = (r_sga ^ r_sgb) ? -r_dvd : r_dvd;
      w_r_fin = r_sga ? -r_rem : r_rem;
      if (r_dbz_p) begin
         w_q_fin = '0;
         w_r_fin = r_a;
      end else if (r_ovf_p) begin
         w_q_fin = MIN_NEG;
         w_r_fin = '0;
      end
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Next-state logic: capture, N iterations, one finishing cycle.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next = S_CALC;
         S_CALC:  if (r_cnt == CNT_ONE) w_next = S_FIN;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath and output registers: operand capture, iteration, result latch.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt   <= '0;
         r_rem   <= '0;
         r_dvd   <= '0;
         r_mb    <= '0;
         r_a     <= '0;
         r_sga   <= 1'b0;
         r_sgb   <= 1'b0;
         r_dbz_p <= 1'b0;
         r_ovf_p <= 1'b0;
         o_done  <= 1'b0;
         o_q     <= '0;
         o_r     <= '0;
         o_dbz   <= 1'b0;
         o_ovf   <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_sga   <= i_a[N-1];
                  r_sgb   <= i_b[N-1];
                  r_dvd   <= w_ma;
                  r_mb    <= w_mb;
                  r_a     <= i_a;
                  r_rem   <= '0;
                  r_cnt   <= CNT_INIT;
                  r_dbz_p <= (i_b == '0);
                  r_ovf_p <= (i_a == MIN_NEG) && (i_b == '1);
               end
            end
            S_CALC: begin
               r_rem <= w_qbit ? w_trial[N-1:0] : w_shift[N-1:0];
               r_dvd <= {r_dvd[N-2:0], w_qbit};
               r_cnt <= r_cnt - CNT_ONE;
            end
            S_FIN: begin
               o_q    <= w_q_fin;
               o_r    <= w_r_fin;
               o_dbz  <= r_dbz_p;
               o_ovf  <= r_ovf_p & ~r_dbz_p;
               o_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
